pnr_trigger_gen: RTL and testbench

PNR_TRIGGER_GEN -- requirements
Module: pnr_trigger_gen

---
 rtl/pnr_trigger_gen.sv | 114 +++++++++++
 tb/tb_pnr_trigger_gen.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pnr_trigger_gen.sv
// ---------------------------------------------------------------------------
// pnr_trigger_gen : threshold-crossing trigger with delayed sample strobe
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pnr_trigger_gen #(
  parameter int DW = 14,
  parameter int CW = 16
) (
  input  logic          ADC_CLK,
  input  logic          rstn_i,
  input  logic          enable_i,
  input  logic [DW-1:0] adc_i,
  input  logic [DW-1:0] trig_threshold_i,
  input  logic [CW-1:0] delay_cycles_i,
  input  logic [CW-1:0] holdoff_cycles_i,
  input  logic          cnt_clr_i,
  output logic          trigger,
  output logic          delayed_trigger,
  output logic          busy_o,
  output logic [31:0]   trig_count_o,
  output logic [15:0]   miss_count_o
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARMED   = 2'd1;
  localparam logic [1:0] DELAY   = 2'd2;
  localparam logic [1:0] HOLDOFF = 2'd3;

  logic [1:0]           state;
  logic signed [DW-1:0] s_cur;
  logic signed [DW-1:0] s_prev;
  logic                 cross_r;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        hold_lat;
  logic                 crossing;
  logic                 fire;
  logic                 miss_ev;

  // The crossing flag is registered once more so trigger lands two edges after
  // the sample that first exceeds the threshold.
  assign crossing = (s_cur > $signed(trig_threshold_i)) &&
                    (s_prev <= $signed(trig_threshold_i));

  assign fire    = enable_i && (state == ARMED) && cross_r;
  assign miss_ev = enable_i && ((state == DELAY) || (state == HOLDOFF)) && cross_r;
  assign busy_o  = (state == DELAY) || (state == HOLDOFF);

  always_ff @(posedge ADC_CLK) begin
    if (!rstn_i) begin
      state           <= IDLE;
      s_cur           <= '0;
      s_prev          <= '0;
      cross_r         <= 1'b0;
      cnt             <= '0;
      hold_lat        <= '0;
      trigger         <= 1'b0;
      delayed_trigger <= 1'b0;
    end else begin
      s_cur           <= $signed(adc_i);
      s_prev          <= s_cur;
      cross_r         <= crossing;
      trigger         <= 1'b0;
      delayed_trigger <= 1'b0;
      if (!enable_i) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: state <= ARMED;
          ARMED: begin
            if (cross_r) begin
              state    <= DELAY;
              trigger  <= 1'b1;
              cnt      <= (delay_cycles_i == '0) ? CW'(1) : delay_cycles_i;
              hold_lat <= holdoff_cycles_i;
            end
          end
          DELAY: begin
            if (cnt == CW'(1)) begin
              delayed_trigger <= 1'b1;
              state           <= HOLDOFF;
              cnt             <= hold_lat;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          HOLDOFF: begin
            if (cnt == '0) state <= ARMED;
            else           cnt   <= cnt - CW'(1);
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Clear wins over a coincident event; the miss counter saturates.
  always_ff @(posedge ADC_CLK) begin
    if (!rstn_i) begin
      trig_count_o <= '0;
      miss_count_o <= '0;
    end else if (cnt_clr_i) begin
      trig_count_o <= '0;
      miss_count_o <= '0;
    end else begin
      if (fire)                                   trig_count_o <= trig_count_o + 32'd1;
      if (miss_ev && (miss_count_o != 16'hFFFF))  miss_count_o <= miss_count_o + 16'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pnr_trigger_gen.sv
// Directed testbench for pnr_trigger_gen; counts edges relative to the first
// above-threshold sample (edge 1 = edge k).
`default_nettype none

module tb_pnr_trigger_gen;

  logic               clk = 1'b0;
  logic               rstn;
  logic               enable;
  logic signed [13:0] adc;
  logic signed [13:0] th;
  logic [15:0]        dly;
  logic [15:0]        hld;
  logic               cnt_clr;
  logic               trigger;
  logic               delayed_trigger;
  logic               busy;
  logic [31:0]        trig_count;
  logic [15:0]        miss_count;

  int n_tests = 0;
  int n_fail  = 0;
  int rel, ntrig, ndel, first_trig, first_del, busy_first, busy_last, coinc;

  always #5 clk = ~clk;

  pnr_trigger_gen #(.DW(14), .CW(16)) dut (
    .ADC_CLK          (clk),
    .rstn_i           (rstn),
    .enable_i         (enable),
    .adc_i            (adc),
    .trig_threshold_i (th),
    .delay_cycles_i   (dly),
    .holdoff_cycles_i (hld),
    .cnt_clr_i        (cnt_clr),
    .trigger          (trigger),
    .delayed_trigger  (delayed_trigger),
    .busy_o           (busy),
    .trig_count_o     (trig_count),
    .miss_count_o     (miss_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic clear_watch();
    rel = 0; ntrig = 0; ndel = 0; coinc = 0;
    first_trig = -1; first_del = -1; busy_first = -1; busy_last = -1;
  endtask

  task automatic watch(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rel++;
      if (trigger) begin ntrig++; if (first_trig < 0) first_trig = rel; end
      if (delayed_trigger) begin ndel++; if (first_del < 0) first_del = rel; end
      if (busy) begin if (busy_first < 0) busy_first = rel; busy_last = rel; end
      if (trigger && delayed_trigger) coinc = 1;
    end
  endtask

  initial begin
    rstn = 1'b0; enable = 1'b1; cnt_clr = 1'b1; adc = 14'sd200; th = 14'sd100;
    dly = 16'd5; hld = 16'd3;
    clear_watch();
    watch(3);
    check("rst_trigger", {31'd0, trigger}, 32'd0);
    check("rst_delayed", {31'd0, delayed_trigger}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_trig_count", trig_count, 32'd0);
    check("rst_miss_count", {16'd0, miss_count}, 32'd0);

    rstn = 1'b1; cnt_clr = 1'b0; adc = 14'sd0;
    watch(3);

    // basic step 0 -> 200, D=5 H=3
    clear_watch(); adc = 14'sd200; watch(15);
    check("basic_first_trig", first_trig, 32'd3);
    check("basic_ntrig", ntrig, 32'd1);
    check("basic_first_del", first_del, 32'd8);
    check("basic_ndel", ndel, 32'd1);
    check("basic_busy_first", busy_first, 32'd3);
    check("basic_busy_last", busy_last, 32'd11);
    check("basic_trig_count", trig_count, 32'd1);

    // held high: no re-fire; then fresh crossing fires again
    clear_watch(); watch(100);
    check("hold_high_ntrig", ntrig, 32'd0);
    adc = 14'sd0; watch(2);
    clear_watch(); adc = 14'sd200; watch(15);
    check("rearm_first_trig", first_trig, 32'd3);
    check("rearm_trig_count", trig_count, 32'd2);

    // D=0 behaves as D=1, H=0 returns to ARMED right after delayed_trigger
    dly = 16'd0; hld = 16'd0; adc = 14'sd0; watch(2);
    clear_watch(); adc = 14'sd200; watch(8);
    check("d0_first_trig", first_trig, 32'd3);
    check("d0_first_del", first_del, 32'd4);
    check("d0_coincident", coinc, 32'd0);
    check("d0_busy_last", busy_last, 32'd4);

    // crossing during DELAY is a miss; D change during DELAY is ignored
    cnt_clr = 1'b1; watch(1); cnt_clr = 1'b0;
    check("clr_trig_count", trig_count, 32'd0);
    check("clr_miss_count", {16'd0, miss_count}, 32'd0);
    dly = 16'd5; hld = 16'd3; adc = 14'sd0; watch(2);
    clear_watch(); adc = 14'sd200; watch(1);
    adc = 14'sd0; watch(1);
    adc = 14'sd200; watch(1);
    dly = 16'd50; watch(12);
    check("miss_ntrig", ntrig, 32'd1);
    check("miss_latched_del", first_del, 32'd8);
    check("miss_count_1", {16'd0, miss_count}, 32'd1);
    check("miss_trig_count", trig_count, 32'd1);

    // miss counter saturation
    force dut.miss_count_o = 16'hFFFF; #1; release dut.miss_count_o;
    check("miss_preload", {16'd0, miss_count}, 32'h0000FFFF);
    dly = 16'd5; adc = 14'sd0; watch(2);
    clear_watch(); adc = 14'sd200; watch(1);
    adc = 14'sd0; watch(1);
    adc = 14'sd200; watch(13);
    check("miss_saturate", {16'd0, miss_count}, 32'h0000FFFF);
    check("sat_trig_count", trig_count, 32'd2);

    // clear coincident with a trigger: pulse still happens, count stays 0
    adc = 14'sd0; watch(2);
    clear_watch(); adc = 14'sd200; watch(2);
    cnt_clr = 1'b1; watch(1); cnt_clr = 1'b0;
    check("clr_prio_pulse", {31'd0, trigger}, 32'd1);
    check("clr_prio_count", trig_count, 32'd0);
    watch(12);

    // enable dropped at k+4 with D=10
    dly = 16'd10; hld = 16'd3; adc = 14'sd0; watch(2);
    clear_watch(); adc = 14'sd200; watch(4);
    enable = 1'b0; watch(1);
    check("en_off_busy", {31'd0, busy}, 32'd0);
    watch(15);
    check("en_off_ndel", ndel, 32'd0);
    check("en_off_busy_last", busy_last, 32'd4);
    check("en_off_first_trig", first_trig, 32'd3);
    enable = 1'b1;

    // reset mid-HOLDOFF
    adc = 14'sd0; watch(2);
    dly = 16'd2; hld = 16'd10;
    clear_watch(); adc = 14'sd200; watch(7);
    check("hold_first_del", first_del, 32'd5);
    rstn = 1'b0; adc = 14'sd0; watch(1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_trigger", {31'd0, trigger}, 32'd0);
    check("mid_rst_delayed", {31'd0, delayed_trigger}, 32'd0);
    check("mid_rst_trig_count", trig_count, 32'd0);
    check("mid_rst_miss_count", {16'd0, miss_count}, 32'd0);
    rstn = 1'b1; watch(20);
    check("post_rst_ndel", ndel, 32'd1);
    check("post_rst_ntrig", ntrig, 32'd1);

    // signed compare: 10 -> -10 with th=50 must not fire
    th = 14'sd50; adc = 14'sd10; dly = 16'd1; hld = 16'd0; watch(3);
    clear_watch(); adc = -14'sd10; watch(6);
    check("signed_no_fire", ntrig, 32'd0);
    // negative threshold: -100 -> -10 with th=-50 fires
    th = -14'sd50; adc = -14'sd100; watch(3);
    clear_watch(); adc = -14'sd10; watch(6);
    check("neg_th_first_trig", first_trig, 32'd3);
    check("neg_th_first_del", first_del, 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
